// File: rtl/specific_counter_ctrl.sv
// specific_counter_ctrl
// Burst sequencer for the 3-bit specific-sequence counter. A start command
// optionally clears the counter for one cycle, then holds the counter enable
// high for exactly the programmed number of cycles. The burst can be paused
// or aborted, and a one-cycle done pulse marks normal completion.
//
// Command semantics (there is no valid/ready pair on this block):
//   - start is a strobe that is only looked at in IDLE or DONE. In CLEAR, RUN
//     and HOLD it is ignored, along with steps and clear_first. Keeping start
//     high through the DONE cycle launches the next burst with no IDLE gap.
//   - pause and abort are levels. They only act in CLEAR, RUN and HOLD.
//   - Priority is reset > abort > pause > normal sequencing.
module specific_counter_ctrl #(
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              clear_first,
    input  logic [STEP_W-1:0] steps,
    input  logic              pause,
    input  logic              abort,
    output logic              cnt_enable,
    output logic              cnt_reset,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] steps_left,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [STEP_W-1:0] steps_left_nxt;
    logic              run_step;

    // A real counting cycle: RUN with nothing holding it back. The counter
    // enable and the steps_left decrement both come from this one term so the
    // two can never disagree.
    assign run_step = (state == RUN) && !pause && !abort && !reset;

    // State and remaining-step register; reset returns to IDLE with nothing left.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            steps_left <= '0;
        end else begin
            state      <= state_nxt;
            steps_left <= steps_left_nxt;
        end
    end

    // Next-state and steps_left update.
    always_comb begin
        state_nxt      = state;
        steps_left_nxt = steps_left;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    steps_left_nxt = steps;
                    if (clear_first) begin
                        state_nxt = CLEAR;
                    end else if (steps != '0) begin
                        state_nxt = RUN;
                    end else begin
                        state_nxt = DONE;
                    end
                end else if (state == DONE) begin
                    state_nxt = IDLE;
                end
            end
            CLEAR: begin
                if (abort) begin
                    state_nxt      = IDLE;
                    steps_left_nxt = '0;
                end else if (steps_left != '0) begin
                    state_nxt = RUN;
                end else begin
                    state_nxt = DONE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt      = IDLE;
                    steps_left_nxt = '0;
                end else if (pause) begin
                    // No decrement: the enable is low in this cycle.
                    state_nxt = HOLD;
                end else begin
                    if (steps_left != '0) begin
                        steps_left_nxt = steps_left - 1'b1;
                    end
                    // Last step (or a defensive zero) finishes the burst.
                    if (steps_left <= STEP_W'(1)) begin
                        state_nxt = DONE;
                    end
                end
            end
            HOLD: begin
                if (abort) begin
                    state_nxt      = IDLE;
                    steps_left_nxt = '0;
                end else if (!pause) begin
                    // The cycle spent here after pause drops is the idle gap
                    // before counting resumes.
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt      = IDLE;
                steps_left_nxt = '0;
            end
        endcase
    end

    // Moore outputs, plus the pause/abort gating on the enable and the
    // system reset folded into the counter reset.
    always_comb begin
        cnt_enable = run_step;
        cnt_reset  = (state == CLEAR) || reset;
        busy       = (state == CLEAR) || (state == RUN) || (state == HOLD);
        done       = (state == DONE);
        state_dbg  = state;
    end

endmodule

// File: tb/tb_specific_counter_ctrl.sv
// tb_specific_counter_ctrl
// Bench for specific_counter_ctrl. Each burst's expected per-cycle outputs are
// built from the timing rules (optional clear cycle, N enable cycles, P+1
// extra cycles per pause of P cycles, then a done cycle) and compared cycle
// by cycle.
module tb_specific_counter_ctrl;

    localparam int STEP_W = 4;

    logic              clk;
    logic              reset;
    logic              start;
    logic              clear_first;
    logic [STEP_W-1:0] steps;
    logic              pause;
    logic              abort;
    logic              cnt_enable;
    logic              cnt_reset;
    logic              busy;
    logic              done;
    logic [STEP_W-1:0] steps_left;
    logic [2:0]        state_dbg;

    int checks   = 0;
    int failures = 0;

    specific_counter_ctrl #(.STEP_W(STEP_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .clear_first (clear_first),
        .steps       (steps),
        .pause       (pause),
        .abort       (abort),
        .cnt_enable  (cnt_enable),
        .cnt_reset   (cnt_reset),
        .busy        (busy),
        .done        (done),
        .steps_left  (steps_left),
        .state_dbg   (state_dbg)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // Observed output vector: {enable, reset, busy, done, steps_left}.
    function automatic logic [7:0] obs();
        return {cnt_enable, cnt_reset, busy, done, steps_left};
    endfunction

    function automatic logic [7:0] ent(input bit en, input bit rs, input bit bz,
                                       input bit dn, input int sl);
        return {en, rs, bz, dn, 4'(sl)};
    endfunction

    // Launch a burst: drives start for the current cycle (caller sits just after a posedge).
    task automatic launch(input int n, input bit clr);
        start       = 1'b1;
        steps       = 4'(n);
        clear_first = clr;
    endtask

    // Runs one burst whose start is already driven in the current cycle.
    // p_at/p_len: pause window placed where enable index p_at would have been.
    // ab_en: abort in the cycle of enable index ab_en (-1 = none).
    // chain: hold start in the done cycle with the next burst's parameters.
    task automatic run_burst(input string name, input int n, input bit clr,
                             input int p_at, input int p_len, input int ab_en,
                             input bit chain, input int nn, input bit nclr);
        logic [7:0] exp_q[$];
        logic [7:0] e;
        int en_idx[$];
        int pz_start = -1;
        int ab_cyc   = -1;
        int en_cnt   = 0;
        int exp_en;
        bit aborted  = 0;
        if (clr) exp_q.push_back(ent(0, 1, 1, 0, n));
        for (int i = 0; i < n; i++) begin
            if (i == p_at && p_len > 0) begin
                pz_start = exp_q.size();
                repeat (p_len + 1) exp_q.push_back(ent(0, 0, 1, 0, n - i));
            end
            en_idx.push_back(exp_q.size());
            exp_q.push_back(ent(1, 0, 1, 0, n - i));
        end
        exp_q.push_back(ent(0, 0, 0, 1, 0));
        if (ab_en >= 0) ab_cyc = en_idx[ab_en];

        for (int t = 0; t < exp_q.size(); t++) begin
            @(posedge clk);
            #1;
            start       = 1'b0;
            abort       = 1'b0;
            pause       = (pz_start >= 0) && (t >= pz_start) && (t < pz_start + p_len);
            e           = exp_q[t];
            if (t == exp_q.size() - 1) begin
                // Abort in DONE has no effect.
                abort = 1'($urandom_range(0, 1));
                if (chain) launch(nn, nclr);
            end else begin
                // Commands while busy must be ignored.
                start       = 1'($urandom_range(0, 1));
                steps       = 4'($urandom_range(0, 15));
                clear_first = 1'($urandom_range(0, 1));
            end
            if (t == ab_cyc) begin
                abort = 1'b1;
                e     = {1'b0, e[6], 1'b1, 1'b0, e[3:0]};
            end
            @(negedge clk);
            if (cnt_enable) en_cnt++;
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL %s cycle %0d: actual {en,rst,busy,done,left}=%b required=%b",
                         name, t, obs(), e);
            end
            if (t == ab_cyc) begin
                aborted = 1;
                break;
            end
        end

        exp_en = (ab_en >= 0) ? ab_en : n;
        checks++;
        if (en_cnt !== exp_en) begin
            failures++;
            $display("FAIL %s enable count: actual=%0d required=%0d", name, en_cnt, exp_en);
        end

        if (aborted || !chain) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            abort = 1'($urandom_range(0, 1));
            pause = 1'b0;
            @(negedge clk);
            checks++;
            if (obs() !== 8'h00) begin
                failures++;
                $display("FAIL %s idle after: actual=%b required=%b", name, obs(), 8'h00);
            end
            abort = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; clear_first = 1'b0; steps = '0; pause = 1'b0; abort = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs() !== 8'b0100_0000) begin
            failures++;
            $display("FAIL reset_values: actual=%b required=%b", obs(), 8'b0100_0000);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (obs() !== 8'h00) begin
            failures++;
            $display("FAIL after_reset: actual=%b required=%b", obs(), 8'h00);
        end
    endtask

    task automatic test_basic();
        @(posedge clk); #1; launch(5, 0);
        run_burst("basic_n5", 5, 0, -1, 0, -1, 0, 0, 0);
    endtask

    task automatic test_clear();
        @(posedge clk); #1; launch(3, 1);
        run_burst("clear_n3", 3, 1, -1, 0, -1, 0, 0, 0);
    endtask

    task automatic test_pause();
        @(posedge clk); #1; launch(6, 0);
        run_burst("pause_n6", 6, 0, 2, 2, -1, 0, 0, 0);
    endtask

    task automatic test_abort();
        @(posedge clk); #1; launch(7, 0);
        run_burst("abort_n7", 7, 0, -1, 0, 3, 0, 0, 0);
        @(posedge clk); #1; launch(2, 0);
        run_burst("after_abort", 2, 0, -1, 0, -1, 0, 0, 0);
    endtask

    task automatic test_zero_steps();
        @(posedge clk); #1; launch(0, 0);
        run_burst("zero_noclr", 0, 0, -1, 0, -1, 0, 0, 0);
        @(posedge clk); #1; launch(0, 1);
        run_burst("zero_clr", 0, 1, -1, 0, -1, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1; launch(4, 0);
        run_burst("b2b_first", 4, 0, -1, 0, -1, 1, 2, 1);
        run_burst("b2b_second", 2, 1, -1, 0, -1, 1, 0, 0);
        run_burst("b2b_third", 0, 0, -1, 0, -1, 0, 0, 0);
    endtask

    task automatic test_reset_mid_run();
        @(posedge clk); #1; launch(7, 0);
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        checks++;
        if (obs() !== ent(1, 0, 1, 0, 7)) begin
            failures++;
            $display("FAIL rst_mid run1: actual=%b required=%b", obs(), ent(1, 0, 1, 0, 7));
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (obs() !== ent(1, 0, 1, 0, 6)) begin
            failures++;
            $display("FAIL rst_mid run2: actual=%b required=%b", obs(), ent(1, 0, 1, 0, 6));
        end
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        checks++;
        if (cnt_reset !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid cnt_reset1: actual=%b required=1", cnt_reset);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (obs() !== 8'b0100_0000) begin
            failures++;
            $display("FAIL rst_mid held: actual=%b required=%b", obs(), 8'b0100_0000);
        end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (obs() !== 8'h00) begin
            failures++;
            $display("FAIL rst_mid released: actual=%b required=%b", obs(), 8'h00);
        end
        @(posedge clk); #1; launch(3, 0);
        run_burst("after_reset_mid", 3, 0, -1, 0, -1, 0, 0, 0);
    endtask

    task automatic test_random();
        int  cur_n;
        bit  cur_clr;
        bit  launched = 0;
        int  p_at, p_len, ab_en, nn;
        bit  chain, nclr;
        for (int k = 0; k < 40; k++) begin
            if (!launched) begin
                cur_n   = $urandom_range(0, 15);
                cur_clr = 1'($urandom_range(0, 1));
                @(posedge clk); #1; launch(cur_n, cur_clr);
            end
            p_at  = (cur_n > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(0, cur_n - 1) : -1;
            p_len = $urandom_range(1, 3);
            ab_en = (cur_n > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, cur_n - 1) : -1;
            if (ab_en >= 0) p_at = -1;
            chain = (ab_en < 0) && (k < 39) && ($urandom_range(0, 1) == 1);
            nn    = $urandom_range(0, 15);
            nclr  = 1'($urandom_range(0, 1));
            run_burst("random", cur_n, cur_clr, p_at, p_len, ab_en, chain, nn, nclr);
            launched = chain;
            if (chain) begin
                cur_n   = nn;
                cur_clr = nclr;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clear();
        test_pause();
        test_abort();
        test_zero_steps();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
